// File: rtl/ex_mem.sv
// EX/MEM pipeline register: latches EX results for MEM, inserts bubbles under stall,
// and holds the intermediate product/count for two-cycle multiply-accumulate ops.
module ex_mem #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned STALL_W = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [STALL_W-1:0]  stall,
  input  logic                flush,
  input  logic [ADDR_W-1:0]   ex_wd,
  input  logic                ex_wreg,
  input  logic [DATA_W-1:0]   ex_wdata,
  input  logic [DATA_W-1:0]   ex_hi,
  input  logic [DATA_W-1:0]   ex_lo,
  input  logic                ex_whilo,
  input  logic [2*DATA_W-1:0] hilo_i,
  input  logic [1:0]          cnt_i,
  output logic [ADDR_W-1:0]   mem_wd,
  output logic                mem_wreg,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W-1:0]   mem_hi,
  output logic [DATA_W-1:0]   mem_lo,
  output logic                mem_whilo,
  output logic [2*DATA_W-1:0] hilo_o,
  output logic [1:0]          cnt_o
);

  logic ex_stall;
  logic mem_stall;

  assign ex_stall  = stall[3];
  assign mem_stall = stall[4];

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      mem_wd    <= '0;
      mem_wreg  <= 1'b0;
      mem_wdata <= '0;
      mem_hi    <= '0;
      mem_lo    <= '0;
      mem_whilo <= 1'b0;
      hilo_o    <= '0;
      cnt_o     <= '0;
    end else if (ex_stall && !mem_stall) begin
      // Bubble into MEM while EX keeps its MAC intermediate alive here.
      mem_wd    <= '0;
      mem_wreg  <= 1'b0;
      mem_wdata <= '0;
      mem_hi    <= '0;
      mem_lo    <= '0;
      mem_whilo <= 1'b0;
      hilo_o    <= hilo_i;
      cnt_o     <= cnt_i;
    end else if (!ex_stall) begin
      mem_wd    <= ex_wd;
      mem_wreg  <= ex_wreg;
      mem_wdata <= ex_wdata;
      mem_hi    <= ex_hi;
      mem_lo    <= ex_lo;
      mem_whilo <= ex_whilo;
      hilo_o    <= '0;
      cnt_o     <= '0;
    end else begin
      // Both EX and MEM stalled: MEM group holds, MAC group refreshes.
      hilo_o    <= hilo_i;
      cnt_o     <= cnt_i;
    end
  end

endmodule

// File: tb/tb_ex_mem.sv
// Self-checking bench for ex_mem: directed scenarios plus randomized traffic
// against a transaction-level reference model.
module tb_ex_mem;

  typedef struct packed {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        whilo;
  } mem_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [4:0]  ex_wd;
  logic        ex_wreg;
  logic [31:0] ex_wdata;
  logic [31:0] ex_hi;
  logic [31:0] ex_lo;
  logic        ex_whilo;
  logic [63:0] hilo_i;
  logic [1:0]  cnt_i;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic [31:0] mem_hi;
  logic [31:0] mem_lo;
  logic        mem_whilo;
  logic [63:0] hilo_o;
  logic [1:0]  cnt_o;

  int vectors = 0;
  int miscompares = 0;

  mem_t        exp_mem;
  logic [63:0] exp_hilo;
  logic [1:0]  exp_cnt;
  mem_t        dut_mem;

  assign dut_mem = {mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_whilo};

  always #5 clk = ~clk;

  ex_mem dut (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall),
    .flush     (flush),
    .ex_wd     (ex_wd),
    .ex_wreg   (ex_wreg),
    .ex_wdata  (ex_wdata),
    .ex_hi     (ex_hi),
    .ex_lo     (ex_lo),
    .ex_whilo  (ex_whilo),
    .hilo_i    (hilo_i),
    .cnt_i     (cnt_i),
    .mem_wd    (mem_wd),
    .mem_wreg  (mem_wreg),
    .mem_wdata (mem_wdata),
    .mem_hi    (mem_hi),
    .mem_lo    (mem_lo),
    .mem_whilo (mem_whilo),
    .hilo_o    (hilo_o),
    .cnt_o     (cnt_o)
  );

  // Reference: the next state of both register groups from the operation rules.
  function automatic void model_step();
    mem_t ex_rec;
    ex_rec = '{wd: ex_wd, wreg: ex_wreg, wdata: ex_wdata, hi: ex_hi, lo: ex_lo,
               whilo: ex_whilo};
    if (!rst || flush) begin
      exp_mem  = '0;
      exp_hilo = '0;
      exp_cnt  = '0;
    end else if (!stall[3]) begin
      exp_mem  = ex_rec;
      exp_hilo = '0;
      exp_cnt  = '0;
    end else begin
      if (!stall[4]) exp_mem = '0;
      exp_hilo = hilo_i;
      exp_cnt  = cnt_i;
    end
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_random_ex();
    ex_wd    = 5'($urandom);
    ex_wreg  = 1'($urandom);
    ex_wdata = $urandom;
    ex_hi    = $urandom;
    ex_lo    = $urandom;
    ex_whilo = 1'($urandom);
    hilo_i   = {$urandom, $urandom};
    cnt_i    = 2'($urandom);
  endtask

  task automatic test_reset();
    rst = 1'b0; flush = 1'b1; stall = 6'b111111;
    ex_wd = 5'h1f; ex_wreg = 1'b1; ex_wdata = 32'hFFFF_FFFF; ex_hi = 32'h1; ex_lo = 32'h2;
    ex_whilo = 1'b1; hilo_i = 64'hFFFF_FFFF_FFFF_FFFF; cnt_i = 2'd3;
    for (int i = 0; i < 2; i++) begin
      tick();
      vectors++;
      if ({dut_mem, hilo_o, cnt_o} !== '0) begin
        miscompares++;
        $display("FAIL reset: got mem=%h hilo=%h cnt=%0d, want all zero", dut_mem, hilo_o, cnt_o);
      end
    end
    rst = 1'b1; flush = 1'b0; stall = '0; ex_wdata = 32'h0BAD_F00D;
    tick();
    vectors++;
    if (mem_wdata !== 32'h0BAD_F00D) begin
      miscompares++;
      $display("FAIL reset_release: mem_wdata=%h want %h", mem_wdata, 32'h0BAD_F00D);
    end
  endtask

  task automatic test_pass_through();
    stall = '0; flush = 1'b0;
    ex_wd = 5'd3; ex_wreg = 1'b1; ex_wdata = 32'h1234_5678; ex_whilo = 1'b1;
    ex_hi = 32'hA; ex_lo = 32'hB; hilo_i = 64'h55; cnt_i = 2'd1;
    tick();
    vectors++;
    if (dut_mem !== {5'd3, 1'b1, 32'h1234_5678, 32'hA, 32'hB, 1'b1} || hilo_o !== '0 ||
        cnt_o !== '0) begin
      miscompares++;
      $display("FAIL pass_through: mem=%h hilo=%h cnt=%0d want mem=%h hilo=0 cnt=0",
               dut_mem, hilo_o, cnt_o, {5'd3, 1'b1, 32'h1234_5678, 32'hA, 32'hB, 1'b1});
    end
  endtask

  task automatic test_bubble();
    stall = 6'b001111; ex_wreg = 1'b1; ex_wdata = 32'hFFFF_FFFF; ex_whilo = 1'b1;
    tick();
    vectors++;
    if (mem_wreg !== 1'b0 || mem_wdata !== '0 || mem_whilo !== 1'b0) begin
      miscompares++;
      $display("FAIL bubble: wreg=%b wdata=%h whilo=%b want 0/0/0", mem_wreg, mem_wdata,
               mem_whilo);
    end
  endtask

  task automatic test_mac();
    stall = 6'b001111; hilo_i = 64'h0000_0001_0000_0002; cnt_i = 2'd1;
    tick();
    vectors++;
    if (hilo_o !== 64'h0000_0001_0000_0002 || cnt_o !== 2'd1 || mem_whilo !== 1'b0) begin
      miscompares++;
      $display("FAIL mac_edge1: hilo=%h cnt=%0d whilo=%b want 0000000100000002/1/0",
               hilo_o, cnt_o, mem_whilo);
    end
    stall = '0; ex_whilo = 1'b1; ex_hi = 32'd1; ex_lo = 32'd5; cnt_i = 2'd2;
    hilo_i = 64'h1234;
    tick();
    vectors++;
    if (mem_hi !== 32'd1 || mem_lo !== 32'd5 || mem_whilo !== 1'b1 || hilo_o !== '0 ||
        cnt_o !== '0) begin
      miscompares++;
      $display("FAIL mac_edge2: hi=%h lo=%h whilo=%b hilo=%h cnt=%0d want 1/5/1/0/0",
               mem_hi, mem_lo, mem_whilo, hilo_o, cnt_o);
    end
  endtask

  task automatic test_mem_hold();
    stall = '0; ex_wdata = 32'hDEAD_BEEF;
    tick();
    stall = 6'b011111;
    for (int i = 0; i < 3; i++) begin
      ex_wdata = $urandom;
      hilo_i   = {$urandom, $urandom};
      cnt_i    = 2'($urandom);
      tick();
      vectors++;
      if (mem_wdata !== 32'hDEAD_BEEF || hilo_o !== hilo_i || cnt_o !== cnt_i) begin
        miscompares++;
        $display("FAIL mem_hold: wdata=%h hilo=%h cnt=%0d want DEADBEEF/%h/%0d",
                 mem_wdata, hilo_o, cnt_o, hilo_i, cnt_i);
      end
    end
  endtask

  task automatic test_flush();
    stall = 6'b001111; flush = 1'b1; hilo_i = 64'hCAFE_0000_0000_BABE; cnt_i = 2'd1;
    tick();
    vectors++;
    if ({dut_mem, hilo_o, cnt_o} !== '0) begin
      miscompares++;
      $display("FAIL flush: mem=%h hilo=%h cnt=%0d want all zero", dut_mem, hilo_o, cnt_o);
    end
    flush = 1'b0;
  endtask

  task automatic test_random();
    logic [5:0] patterns [4];
    patterns[0] = 6'b000000;
    patterns[1] = 6'b001111;
    patterns[2] = 6'b011111;
    patterns[3] = 6'b111111;
    for (int i = 0; i < 400; i++) begin
      drive_random_ex();
      rst   = ($urandom_range(0, 29) != 0);
      flush = ($urandom_range(0, 14) == 0);
      stall = patterns[$urandom_range(0, 3)];
      if ($urandom_range(0, 7) == 0) stall = 6'($urandom);
      tick();
      vectors++;
      if (dut_mem !== exp_mem || hilo_o !== exp_hilo || cnt_o !== exp_cnt) begin
        miscompares++;
        $display("FAIL random[%0d]: mem=%h hilo=%h cnt=%0d want mem=%h hilo=%h cnt=%0d",
                 i, dut_mem, hilo_o, cnt_o, exp_mem, exp_hilo, exp_cnt);
      end
    end
    rst = 1'b1; flush = 1'b0;
  endtask

  initial begin
    exp_mem = '0; exp_hilo = '0; exp_cnt = '0;
    #1;
    test_reset();
    test_pass_through();
    test_bubble();
    test_mac();
    test_mem_hold();
    test_flush();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
